cpu_hazard_scoreboard: RTL and testbench

//  RAW/WAW interlock controller for the instruction-decode stage. Keeps a per-register

---
 rtl/cpu_hazard_scoreboard.sv | 128 ++++++++++++
 tb/tb_cpu_hazard_scoreboard.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_hazard_scoreboard
//  Purpose  : RAW/WAW interlock for the instruction-decode stage. Tracks a
//             per-register count of in-flight writes (issued at decode,
//             retired at writeback) and requests a decode stall while a
//             source is pending or the destination's pending count is full.
//             Includes a flush path, a sticky underflow error flag and a
//             saturating stall-cycle performance counter.
//  Ports    : clock        - rising-edge clock
//             reset        - asynchronous active-low reset
//             reg_s/reg_t  - decode source registers
//             reg_id_d     - decode destination register
//             issue_valid  - decode hands an instruction downstream
//             issue_writes - issuing instruction writes reg_id_d
//             wb_valid     - writeback retires a register write
//             wb_reg       - register being written back
//             flush        - discard all in-flight writes
//             reg_stall    - stall request to decode (combinational)
//             pending      - bit i set while register i has writes in flight
//             stall_count  - saturating count of stalled cycles
//             sb_error     - sticky writeback-to-non-pending-register flag
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2,
    parameter int PERF_W   = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   reg_s,
    input  logic [ADDR_W-1:0]   reg_t,
    input  logic [ADDR_W-1:0]   reg_id_d,
    input  logic                issue_valid,
    input  logic                issue_writes,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_reg,
    input  logic                flush,
    output logic                reg_stall,
    output logic [NUM_REGS-1:0] pending,
    output logic [PERF_W-1:0]   stall_count,
    output logic                sb_error
);

    localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;
    localparam logic [PERF_W-1:0] C_PERF_MAX = '1;

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [PERF_W-1:0]              stall_count_q, stall_count_d;
    logic                           sb_error_q, sb_error_d;

    logic src_s_busy;
    logic src_t_busy;
    logic dst_full;
    logic issue_accept;
    logic wb_hit;
    logic wb_underflow;

    // Stall decision is made from registered counts only; a writeback in
    // this cycle does not bypass, so the stall drops one cycle later.
    always_comb begin
        src_s_busy   = (reg_s != '0) && (cnt_q[reg_s] != '0);
        src_t_busy   = (reg_t != '0) && (cnt_q[reg_t] != '0);
        dst_full     = issue_writes && (reg_id_d != '0) && (cnt_q[reg_id_d] == C_CNT_MAX);
        reg_stall    = src_s_busy || src_t_busy || dst_full;
        issue_accept = issue_valid && !reg_stall && !flush;
        wb_hit       = wb_valid && (wb_reg != '0);
        wb_underflow = wb_hit && (cnt_q[wb_reg] == '0);
    end

    // Counter next-state. An accepted issue and a valid retire on the same
    // register cancel. A retire against a zero count is dropped (and flagged
    // below). An accepted issue can never overflow because a full
    // destination forces a stall.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            logic inc;
            logic dec;
            inc = issue_accept && issue_writes && (reg_id_d == ADDR_W'(i));
            dec = wb_hit && (wb_reg == ADDR_W'(i)) && (cnt_q[i] != '0);
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        // Register 0 is hard-wired and never tracked.
        cnt_d[0] = '0;
        if (flush) begin
            cnt_d = '0;
        end
    end

    // A flush discards the writeback in the same cycle, so it cannot underflow.
    always_comb begin
        sb_error_d    = sb_error_q || (wb_underflow && !flush);
        stall_count_d = stall_count_q;
        if (reg_stall && (stall_count_q != C_PERF_MAX)) begin
            stall_count_d = stall_count_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            stall_count_q <= '0;
            sb_error_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            sb_error_q    <= sb_error_d;
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_pending
            assign pending[g] = |cnt_q[g];
        end
    endgenerate

    assign stall_count = stall_count_q;
    assign sb_error    = sb_error_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_hazard_scoreboard
//  Purpose  : Self-checking bench for cpu_hazard_scoreboard. Each scenario
//             task walks a small stimulus table; the expected outputs of a
//             step are queued when the step is driven and popped when the
//             outputs are sampled. A small behavioural model tracks the
//             expected stall-cycle count.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_hazard_scoreboard;

    logic        clock;
    logic        reset;
    logic [4:0]  reg_s, reg_t, reg_id_d, wb_reg;
    logic        issue_valid, issue_writes, wb_valid, flush;
    logic        reg_stall;
    logic [31:0] pending;
    logic [15:0] stall_count;
    logic        sb_error;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_hazard_scoreboard #(
        .NUM_REGS(32), .ADDR_W(5), .CNT_W(2), .PERF_W(16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .reg_s       (reg_s),
        .reg_t       (reg_t),
        .reg_id_d    (reg_id_d),
        .issue_valid (issue_valid),
        .issue_writes(issue_writes),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .flush       (flush),
        .reg_stall   (reg_stall),
        .pending     (pending),
        .stall_count (stall_count),
        .sb_error    (sb_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        stall;
        logic [31:0] pend;
        logic        err;
    } exp_t;

    typedef struct {
        string       nm;
        logic        iv, iw;
        logic [4:0]  rd, rs, rt;
        logic        wv;
        logic [4:0]  wr;
        logic        fl;
        exp_t        e;
    } step_t;

    exp_t sb_q[$];

    // Behavioural model of the counts, used for the expected stall_count.
    int          mc[32];
    logic [15:0] m_scount;

    function automatic step_t st(string nm, bit iv, bit iw, int rd, int rs, int rt,
                                 bit wv, int wr, bit fl, bit es, logic [31:0] ep, bit ee);
        step_t s;
        s.nm = nm; s.iv = iv; s.iw = iw;
        s.rd = 5'(rd); s.rs = 5'(rs); s.rt = 5'(rt);
        s.wv = wv; s.wr = 5'(wr); s.fl = fl;
        s.e = '{stall: es, pend: ep, err: ee};
        return s;
    endfunction

    task automatic model_reset();
        foreach (mc[i]) mc[i] = 0;
        m_scount = '0;
    endtask

    task automatic drive(step_t s);
        issue_valid = s.iv; issue_writes = s.iw; reg_id_d = s.rd;
        reg_s = s.rs; reg_t = s.rt; wb_valid = s.wv; wb_reg = s.wr; flush = s.fl;
    endtask

    task automatic drive_idle();
        drive(st("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0));
    endtask

    // Advance the model with the inputs in force, then cross one rising edge.
    task automatic tick();
        bit ms, acc;
        ms = (reg_s != 0 && mc[reg_s] != 0) || (reg_t != 0 && mc[reg_t] != 0) ||
             (issue_writes && reg_id_d != 0 && mc[reg_id_d] == 3);
        if (ms && m_scount != 16'hFFFF) m_scount = m_scount + 16'd1;
        if (flush) begin
            foreach (mc[i]) mc[i] = 0;
        end else begin
            acc = issue_valid && !ms;
            if (wb_valid && wb_reg != 0 && mc[wb_reg] != 0) mc[wb_reg] = mc[wb_reg] - 1;
            if (acc && issue_writes && reg_id_d != 0) mc[reg_id_d] = mc[reg_id_d] + 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reg_s = 5'd3; reg_t = 5'd4; issue_valid = 1; issue_writes = 1; reg_id_d = 5'd7;
        wb_valid = 1; wb_reg = 5'd4;
        @(posedge clock);
        #1;
        sb_q.push_back('{stall: 0, pend: '0, err: 0});
        #3;
        e = sb_q.pop_front();
        n_tests++;
        if ({reg_stall, pending, sb_error} !== e) begin
            n_fail++;
            $display("FAIL reset_state: stall=%b pending=%h err=%b, expected %b %h %b",
                     reg_stall, pending, sb_error, e.stall, e.pend, e.err);
        end
        n_tests++;
        if (stall_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall_count: got %0d expected 0", stall_count);
        end
        @(posedge clock);
        #1;
        drive_idle();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_raw();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(st("raw_issue", 1, 1, 3, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(st("raw_use",   0, 0, 0, 3, 0, 0, 0, 0, 1, 32'h8, 0));
        tbl.push_back(st("raw_wb",    0, 0, 0, 3, 0, 1, 3, 0, 1, 32'h8, 0));
        tbl.push_back(st("raw_after", 0, 0, 0, 3, 0, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(st("raw_rt",    0, 0, 0, 0, 3, 0, 0, 0, 0, 32'h0, 0));
        foreach (tbl[k]) begin
            drive(tbl[k]);
            sb_q.push_back(tbl[k].e);
            #3;
            e = sb_q.pop_front();
            n_tests++;
            if ({reg_stall, pending, sb_error} !== e) begin
                n_fail++;
                $display("FAIL %s: stall=%b pending=%h err=%b, expected %b %h %b",
                         tbl[k].nm, reg_stall, pending, sb_error, e.stall, e.pend, e.err);
            end
            tick();
        end
        n_tests++;
        if (stall_count !== 16'd2) begin
            n_fail++;
            $display("FAIL raw_stall_count: got %0d expected 2", stall_count);
        end
    endtask

    task automatic test_waw();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(st("waw_iss1",  1, 1, 7, 0, 0, 0, 0, 0, 0, 32'h00, 0));
        tbl.push_back(st("waw_iss2",  1, 1, 7, 0, 0, 0, 0, 0, 0, 32'h80, 0));
        tbl.push_back(st("waw_iss3",  1, 1, 7, 0, 0, 0, 0, 0, 0, 32'h80, 0));
        tbl.push_back(st("waw_full",  1, 1, 7, 0, 0, 0, 0, 0, 1, 32'h80, 0));
        tbl.push_back(st("waw_wb",    1, 1, 7, 0, 0, 1, 7, 0, 1, 32'h80, 0));
        tbl.push_back(st("waw_acc",   1, 1, 7, 0, 0, 0, 0, 0, 0, 32'h80, 0));
        tbl.push_back(st("waw_full2", 1, 1, 7, 0, 0, 0, 0, 0, 1, 32'h80, 0));
        tbl.push_back(st("waw_dr1",   0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h80, 0));
        tbl.push_back(st("waw_dr2",   0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h80, 0));
        tbl.push_back(st("waw_dr3",   0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h80, 0));
        tbl.push_back(st("waw_empty", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00, 0));
        foreach (tbl[k]) begin
            drive(tbl[k]);
            sb_q.push_back(tbl[k].e);
            #3;
            e = sb_q.pop_front();
            n_tests++;
            if ({reg_stall, pending, sb_error} !== e) begin
                n_fail++;
                $display("FAIL %s: stall=%b pending=%h err=%b, expected %b %h %b",
                         tbl[k].nm, reg_stall, pending, sb_error, e.stall, e.pend, e.err);
            end
            tick();
        end
        n_tests++;
        if (stall_count !== m_scount) begin
            n_fail++;
            $display("FAIL waw_stall_count: got %0d expected %0d", stall_count, m_scount);
        end
    endtask

    task automatic test_simul();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(st("sim_iss9",  1, 1, 9, 0, 0, 0, 0, 0, 0, 32'h000, 0));
        tbl.push_back(st("sim_both9", 1, 1, 9, 0, 0, 1, 9, 0, 0, 32'h200, 0));
        tbl.push_back(st("sim_wb9a",  0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h200, 0));
        tbl.push_back(st("sim_wb9b",  0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h000, 0));
        tbl.push_back(st("sim_wb0",   0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h000, 1));
        tbl.push_back(st("sim_err",   0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h000, 1));
        foreach (tbl[k]) begin
            drive(tbl[k]);
            sb_q.push_back(tbl[k].e);
            #3;
            e = sb_q.pop_front();
            n_tests++;
            if ({reg_stall, pending, sb_error} !== e) begin
                n_fail++;
                $display("FAIL %s: stall=%b pending=%h err=%b, expected %b %h %b",
                         tbl[k].nm, reg_stall, pending, sb_error, e.stall, e.pend, e.err);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        step_t tbl[$];
        exp_t  e;
        // Asynchronous reset pulse between edges clears the sticky error.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();
        tbl.push_back(st("fl_iss2",  1, 1, 2, 0, 0, 0, 0,  0, 0, 32'h00, 0));
        tbl.push_back(st("fl_iss4",  1, 1, 4, 0, 0, 0, 0,  0, 0, 32'h04, 0));
        tbl.push_back(st("fl_all",   1, 1, 6, 2, 0, 1, 2,  1, 1, 32'h14, 0));
        tbl.push_back(st("fl_wb_np", 0, 0, 0, 0, 0, 1, 11, 1, 0, 32'h00, 0));
        tbl.push_back(st("fl_after", 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h00, 0));
        foreach (tbl[k]) begin
            drive(tbl[k]);
            sb_q.push_back(tbl[k].e);
            #3;
            e = sb_q.pop_front();
            n_tests++;
            if ({reg_stall, pending, sb_error} !== e) begin
                n_fail++;
                $display("FAIL %s: stall=%b pending=%h err=%b, expected %b %h %b",
                         tbl[k].nm, reg_stall, pending, sb_error, e.stall, e.pend, e.err);
            end
            tick();
        end
        n_tests++;
        if (stall_count !== 16'd1) begin
            n_fail++;
            $display("FAIL fl_stall_count_kept: got %0d expected 1", stall_count);
        end
    endtask

    task automatic test_reset_mid();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(st("rm_iss5a", 1, 1, 5, 0, 0, 0, 0, 0, 0, 32'h00, 0));
        tbl.push_back(st("rm_iss5b", 1, 1, 5, 0, 0, 0, 0, 0, 0, 32'h20, 0));
        tbl.push_back(st("rm_use5",  0, 0, 0, 5, 0, 0, 0, 0, 1, 32'h20, 0));
        foreach (tbl[k]) begin
            drive(tbl[k]);
            sb_q.push_back(tbl[k].e);
            #3;
            e = sb_q.pop_front();
            n_tests++;
            if ({reg_stall, pending, sb_error} !== e) begin
                n_fail++;
                $display("FAIL %s: stall=%b pending=%h err=%b, expected %b %h %b",
                         tbl[k].nm, reg_stall, pending, sb_error, e.stall, e.pend, e.err);
            end
            tick();
        end
        // cnt[5]==2 and reg_s=5 still driven; assert reset without an edge.
        reg_s = 5'd5;
        #2;
        reset = 1'b0;
        sb_q.push_back('{stall: 0, pend: '0, err: 0});
        #1;
        e = sb_q.pop_front();
        n_tests++;
        if ({reg_stall, pending, sb_error} !== e || stall_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rm_async: stall=%b pending=%h err=%b count=%0d, expected 0 0 0 0",
                     reg_stall, pending, sb_error, stall_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        drive_idle();
        model_reset();
    endtask

    task automatic test_reg0_perf();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(st("p_iss0", 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(st("p_iss1", 1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(st("p_use1", 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h2, 0));
        foreach (tbl[k]) begin
            drive(tbl[k]);
            sb_q.push_back(tbl[k].e);
            #3;
            e = sb_q.pop_front();
            n_tests++;
            if ({reg_stall, pending, sb_error} !== e) begin
                n_fail++;
                $display("FAIL %s: stall=%b pending=%h err=%b, expected %b %h %b",
                         tbl[k].nm, reg_stall, pending, sb_error, e.stall, e.pend, e.err);
            end
            tick();
        end
        // reg_s=1 stays driven; stall holds well past the counter range.
        repeat (70000) tick();
        #3;
        n_tests++;
        if (stall_count !== 16'hFFFF || stall_count !== m_scount) begin
            n_fail++;
            $display("FAIL perf_saturate: got %h expected FFFF", stall_count);
        end
        n_tests++;
        if (reg_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL perf_stall_held: got %b expected 1", reg_stall);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_raw();
        test_waw();
        test_simul();
        test_flush();
        test_reset_mid();
        test_reg0_perf();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
